// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master turning a valid/ready command stream into SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int RW_REGION      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [RW_REGION-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [RW_REGION-1:0]  paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            dbg_state
);

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready; a response
  // transfers on an edge where rsp_valid && rsp_ready. Valid holds its payload until then.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   timeout_hit;

  assign dbg_state = state;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = !pready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counter sits at zero outside ACCESS, so it is clear on every entry to ACCESS.
  always_ff @(posedge pclk) begin
    if (preset || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!pready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pselx       <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            cmd_ready <= 1'b0;
            pselx     <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_slverr  <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE first means a new command is never taken on the release edge.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: transaction-level model predicts every output cycle of apb_master; a single
// negedge process compares the DUT against the predicted queue.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TC = 16;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          pclk;
  logic          preset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic [1:0]    dbg_state;

  apb_master #(.DATA_WIDTH(DW), .RW_REGION(AW), .TIMEOUT_CYCLES(TC)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic          cmd_ready;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic          rsp_timeout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // bench's own record of the last accepted command
  logic          lat_write;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;

  // observations used by the hand-computed literal checks
  int cyc        = 0;
  int acc_cyc    = 0;
  int prev_acc   = 0;
  int pen_cnt    = 0;
  int rise_lat   = 0;
  int pen_at_rise = 0;
  logic rsp_prev = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      cyc++;
      if (cmd_valid && cmd_ready) begin
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        pen_cnt  = 0;
      end
      if (penable) pen_cnt++;
      if (rsp_valid && !rsp_prev) begin
        rise_lat    = cyc - acc_cyc;
        pen_at_rise = pen_cnt;
      end
      rsp_prev = rsp_valid;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("cmd_ready", DW'(cmd_ready), DW'(e.cmd_ready));
        chk("pselx",     DW'(pselx),     DW'(e.pselx));
        chk("penable",   DW'(penable),   DW'(e.penable));
        chk("pwrite",    DW'(pwrite),    DW'(e.pwrite));
        chk("paddr",     DW'(paddr),     DW'(e.paddr));
        chk("pwdata",    pwdata,         e.pwdata);
        chk("rsp_valid", DW'(rsp_valid), DW'(e.rsp_valid));
        if (e.rsp_valid) begin
          chk("rsp_rdata",   rsp_rdata,          e.rsp_rdata);
          chk("rsp_slverr",  DW'(rsp_slverr),    DW'(e.rsp_slverr));
          chk("rsp_timeout", DW'(rsp_timeout),   DW'(e.rsp_timeout));
        end
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic exp_t mk(input logic cr, input logic ps, input logic pe, input logic rv,
                              input logic [DW-1:0] rd, input logic se, input logic to);
    exp_t e;
    e.cmd_ready   = cr;
    e.pselx       = ps;
    e.penable     = pe;
    e.pwrite      = lat_write;
    e.paddr       = lat_addr;
    e.pwdata      = lat_wdata;
    e.rsp_valid   = rv;
    e.rsp_rdata   = rd;
    e.rsp_slverr  = se;
    e.rsp_timeout = to;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic noise_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic noise_apb();
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = $urandom;
  endtask

  // One transfer: idle cycles, accept, SETUP, ACCESS (waits extra cycles), RESP (hold extra
  // cycles). rst_at >= 0 pulses preset in that ACCESS cycle and abandons the transfer.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] rd, input logic se,
                      input int hold, input int idle, input int rst_at);
    int  alen;
    bit  tmo;
    logic [DW-1:0] exp_rd;
    for (int i = 0; i < idle; i++) begin
      tick();
      noise_cmd();
      cmd_valid = 1'b0;
      noise_apb();
      rsp_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    end
    tick();
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    noise_apb();
    rsp_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    lat_write = w;
    lat_addr  = a;
    lat_wdata = d;
    tick();
    noise_cmd();
    noise_apb();
    rsp_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    tmo  = TMO_EN && (waits > TC);
    alen = tmo ? TC + 1 : waits + 1;
    for (int i = 0; i < alen; i++) begin
      tick();
      noise_cmd();
      noise_apb();
      rsp_ready = 1'($urandom_range(0, 1));
      pready = (!tmo && i == alen - 1);
      if (i == alen - 1 && !tmo) begin
        prdata  = rd;
        pslverr = se;
      end
      preset = (i == rst_at);
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0));
      if (i == rst_at) begin
        tick();
        preset    = 1'b0;
        cmd_valid = 1'b0;
        lat_write = 1'b0;
        lat_addr  = '0;
        lat_wdata = '0;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
        return;
      end
    end
    exp_rd = (tmo || w) ? '0 : rd;
    for (int j = 0; j <= hold; j++) begin
      tick();
      noise_cmd();
      noise_apb();
      rsp_ready = (j == hold);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, exp_rd, tmo ? 1'b1 : se, tmo));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    int rst_at;
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    lat_write = 1'b0;
    lat_addr  = '0;
    lat_wdata = '0;
    repeat (3) @(posedge pclk);
    tick();
    preset = 1'b0;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));

    // write, zero wait states
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0, 0, -1);
    @(negedge pclk); #1;
    chk("lit_wr_latency", DW'(rise_lat), 32'd3);
    chk("lit_wr_rdata", rsp_rdata, 32'h0);
    chk("lit_wr_slverr", DW'(rsp_slverr), 32'h0);

    // back-to-back read with 3 wait states
    xfer(1'b0, 8'h24, 32'h0, 3, 32'h12345678, 1'b0, 0, 0, -1);
    @(negedge pclk); #1;
    chk("lit_rd_latency", DW'(rise_lat), 32'd6);
    chk("lit_rd_penable_cycles", DW'(pen_at_rise), 32'd4);
    chk("lit_rd_rdata", rsp_rdata, 32'h12345678);
    chk("lit_b2b_gap", DW'(acc_cyc - prev_acc), 32'd4);

    // slave error, response held off for 5 cycles
    xfer(1'b0, 8'h30, 32'h0, 1, 32'hA5A5A5A5, 1'b1, 5, 1, -1);
    @(negedge pclk); #1;
    chk("lit_err_slverr", DW'(rsp_slverr), 32'h1);

    // reset during ACCESS
    xfer(1'b1, 8'h44, 32'h01020304, 3, 32'h0, 1'b0, 0, 0, 1);

    // long wait: completes normally without the timeout, aborts with it
    xfer(1'b0, 8'h50, 32'h0, 20, 32'hCAFEF00D, 1'b0, 0, 0, -1);
    @(negedge pclk); #1;
    chk("lit_long_timeout", DW'(rsp_timeout), DW'(TMO_EN));
    xfer(1'b0, 8'h54, 32'h0, TC, 32'h600DF00D, 1'b0, 0, 0, -1);
    @(negedge pclk); #1;
    chk("lit_limit_rdata", rsp_rdata, 32'h600DF00D);

    for (int n = 0; n < 250; n++) begin
      waits  = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? TC : TC + 4)
                                           : int'($urandom_range(0, 5));
      rst_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1;
      xfer(1'($urandom_range(0, 1)), AW'($urandom), $urandom, waits, $urandom,
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 2)), rst_at);
    end

    for (int i = 0; i < 3; i++) begin
      tick();
      noise_cmd();
      cmd_valid = 1'b0;
      noise_apb();
      rsp_ready = 1'b0;
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
    end
    @(negedge pclk); #1;
    chk("queue_drained", DW'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
